issue_stage: RTL
================

ISSUE_STAGE -- requirements
Module: issue_stage

Interface
REQ-001 clock  in  1  clock; all state updates on rising edge.
REQ-002 reset  in  1  reset, asynchronous, active-low.
REQ-003 id_is_instruc  in  32  decoded instruction word; 32'h0 is a bubble.
REQ-004 id_is_addra / id_is_addrb  in  5 each  source register indices (rs, rt).
REQ-005 id_is_regdest  in  5  destination register index.
REQ-006 id_is_writereg  in  1  instruction writes regdest.
REQ-007 id_is_numop  in  2  source operand count: 0, 1 (addra only), 2 (addra+addrb); 3 treated as 2.
REQ-008 id_is_fununit  in  2  target functional unit 0..3.
REQ-009 fu_busy  in  4  per-unit busy; bit n high = unit n cannot accept.
REQ-010 wb_valid / wb_regdest  in  1 / 5  writeback completion; clears scoreboard bit.
REQ-011 is_flush  in  1  discard held instruction (branch redirect).
REQ-012 is_if_stall  out  1  back-pressure to decode; decode holds outputs while high.
REQ-013 is_fu_valid  out  4  one-hot dispatch strobe, registered.
REQ-014 is_fu_instruc / is_fu_regdest / is_fu_writereg  out  32 / 5 / 1  dispatched bundle, registered.

Function
REQ-015 Two-state FSM: EMPTY (no held instruction), HOLD (held instruction awaiting issue).
REQ-016 Holding register SHALL capture the id_is_* bundle on every edge where is_if_stall is low; bubble capture goes to EMPTY, non-bubble to HOLD.
REQ-017 Scoreboard: 32 busy bits; bit 0 SHALL always read 0.
REQ-018 Effective busy = busy bits with this cycle's wb_regdest cleared when wb_valid (writeback bypass).
REQ-019 Issue condition in HOLD: fu_busy[fununit]==0; addra not effective-busy if numop>=1; addrb not effective-busy if numop>=2; regdest not effective-busy if writereg (WAW).
REQ-020 is_if_stall SHALL be combinational: high iff state==HOLD and issue condition false and is_flush low; low in EMPTY.
REQ-021 On issue: next cycle is_fu_valid[fununit]=1 for exactly one cycle, with is_fu_* carrying the held bundle; other bits 0.
REQ-022 On issue with writereg and regdest!=0, busy[regdest] SHALL be set; set wins over same-cycle writeback clear of the same index.
REQ-023 Issue latency: instruction with no hazards SHALL dispatch one cycle after capture (zero wait cycles in HOLD).
REQ-024 is_flush: held instruction SHALL not issue, state to EMPTY, stall low that cycle; scoreboard unchanged; input bundle that cycle is not captured.
REQ-025 Writeback to register 0 or to a non-busy register SHALL have no effect.
REQ-026 is_fu_instruc/regdest/writereg SHALL hold last values when is_fu_valid is 0.

Reset
REQ-027 On reset low: state EMPTY, all busy bits 0, is_fu_valid 4'b0000, is_fu_instruc 32'h0, is_fu_regdest 5'h0, is_fu_writereg 0, is_if_stall 0, stall counter 0.
REQ-028 Reset mid-HOLD SHALL drop the held instruction with no dispatch strobe.

Configuration
REQ-029 Macro ISSUE_STALL_COUNT_EN defined: output stall_count[15:0] increments each cycle is_if_stall is high, saturates at 16'hFFFF, cleared only by reset.
REQ-030 Macro undefined: stall_count port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-031 Back-to-back independent ALU ops to units 0,1 (regdest 8, 9) -> is_fu_valid 4'b0001 then 4'b0010 on consecutive cycles, is_if_stall never high.
REQ-032 RAW: op writes r5, next op numop=2 reads r5; wb_valid/wb_regdest=5 asserted 3 cycles later -> stall high exactly 3 cycles, dependent dispatches cycle after wb (bypass).
REQ-033 fu_busy=4'b0100 with held instruction fununit=2 for 4 cycles -> stall 4 cycles, dispatch on 4'b0100 when fu_busy drops; with macro, stall_count=4.
REQ-034 is_flush in HOLD while stalled -> no strobe, stall low same cycle, state EMPTY, busy bits unchanged.
REQ-035 Issue writing r7 in same cycle as wb_regdest=7 -> busy[7]=1 afterward; writeback to r0 -> no change, r0 never stalls.
REQ-036 Reset asserted mid-HOLD -> all outputs at REQ-027 values immediately (asynchronous), no dispatch after release.

Source files
------------

// File: rtl/issue_stage.sv
// issue_stage -- single-entry in-order issue stage with register scoreboard.
//
// Holds one decoded instruction and dispatches it to one of four functional
// units once its source and destination registers are free and the target
// unit can accept it. A 32-entry scoreboard tracks registers with writes in
// flight. A writeback in the same cycle is bypassed into the hazard check.
//
// Ports
//   clock, reset            clock; asynchronous active-low reset
//   id_is_instruc           decoded instruction word (32'h0 = bubble)
//   id_is_addra/addrb       source register indices
//   id_is_regdest           destination register index
//   id_is_writereg          instruction writes regdest
//   id_is_numop             source operand count (3 behaves as 2)
//   id_is_fununit           target functional unit 0..3
//   fu_busy                 per-unit busy, bit n high = unit n cannot accept
//   wb_valid, wb_regdest    writeback completion, frees a scoreboard entry
//   is_flush                discard the held instruction
//   is_if_stall             combinational back-pressure to decode
//   is_fu_valid             registered one-hot dispatch strobe
//   is_fu_instruc/regdest/writereg  registered dispatched bundle
//   stall_count             saturating stall-cycle counter (only when the
//                           macro ISSUE_STALL_COUNT_EN is defined)
module issue_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] id_is_instruc,
  input  logic [4:0]  id_is_addra,
  input  logic [4:0]  id_is_addrb,
  input  logic [4:0]  id_is_regdest,
  input  logic        id_is_writereg,
  input  logic [1:0]  id_is_numop,
  input  logic [1:0]  id_is_fununit,
  input  logic [3:0]  fu_busy,
  input  logic        wb_valid,
  input  logic [4:0]  wb_regdest,
  input  logic        is_flush,
  output logic        is_if_stall,
  output logic [3:0]  is_fu_valid,
  output logic [31:0] is_fu_instruc,
  output logic [4:0]  is_fu_regdest,
  output logic        is_fu_writereg
`ifdef ISSUE_STALL_COUNT_EN
  ,
  output logic [15:0] stall_count
`endif
);

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t      state, state_next;

  logic [31:0] held_instruc;
  logic [4:0]  held_addra;
  logic [4:0]  held_addrb;
  logic [4:0]  held_regdest;
  logic        held_writereg;
  logic [1:0]  held_numop;
  logic [1:0]  held_fununit;

  logic [31:0] busy, busy_next;
  logic [31:0] wb_mask;
  logic [31:0] eff_busy;
  logic        ready;
  logic        issue;
  logic        capture;

  // Writeback bypass: a register completing this cycle is already free.
  always_comb begin
    wb_mask = '0;
    if (wb_valid) wb_mask[wb_regdest] = 1'b1;
  end

  assign eff_busy = busy & ~wb_mask;

  // Output logic of the FSM: issue strobe and back-pressure.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    ready       = 1'b0;
    issue       = 1'b0;
    is_if_stall = 1'b0;
    if (state == HOLD) begin
      ready = !fu_busy[held_fununit]
           && !((held_numop != 2'd0) && eff_busy[held_addra])
           && !(held_numop[1] && eff_busy[held_addrb])
           && !(held_writereg && eff_busy[held_regdest]);
      issue       = ready && !is_flush;
      is_if_stall = !ready && !is_flush;
    end
  end

  // A flush swallows the incoming bundle as well as the held one.
  assign capture = !is_flush && !is_if_stall;

  // Next-state logic.
  always_comb begin
    state_next = state;
    if (is_flush)     state_next = EMPTY;
    else if (capture) state_next = (id_is_instruc == 32'h0) ? EMPTY : HOLD;
  end

  // Scoreboard update: the issue-time set is applied after the writeback
  // clear so it wins on the same index. Register 0 never becomes busy.
  always_comb begin
    busy_next = busy & ~wb_mask;
    if (issue && held_writereg && (held_regdest != 5'd0))
      busy_next[held_regdest] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample the same pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= state_next;
  end

  // NOTE: the holding register is reset too, even though EMPTY makes its
  // contents don't-care, so that no X ever reaches the dispatch outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      held_instruc  <= 32'h0;
      held_addra    <= 5'h0;
      held_addrb    <= 5'h0;
      held_regdest  <= 5'h0;
      held_writereg <= 1'b0;
      held_numop    <= 2'd0;
      held_fununit  <= 2'd0;
    end else if (capture) begin
      held_instruc  <= id_is_instruc;
      held_addra    <= id_is_addra;
      held_addrb    <= id_is_addrb;
      held_regdest  <= id_is_regdest;
      held_writereg <= id_is_writereg;
      held_numop    <= id_is_numop;
      held_fununit  <= id_is_fununit;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_next;
  end

  // Dispatch registers: the strobe lasts one cycle, the bundle is sticky.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      is_fu_valid    <= 4'b0000;
      is_fu_instruc  <= 32'h0;
      is_fu_regdest  <= 5'h0;
      is_fu_writereg <= 1'b0;
    end else begin
      is_fu_valid <= 4'b0000;
      if (issue) begin
        is_fu_valid[held_fununit] <= 1'b1;
        is_fu_instruc             <= held_instruc;
        is_fu_regdest             <= held_regdest;
        is_fu_writereg            <= held_writereg;
      end
    end
  end

`ifdef ISSUE_STALL_COUNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      stall_count <= 16'h0;
    else if (is_if_stall && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end
`endif

endmodule
